// File: rtl/rib_pkg.sv
// Shared RIB bus constants and master identifiers used by the arbiter and its ID FIFO.
package rib_pkg;

    localparam int unsigned RIB_ADDR_W = 32;
    localparam int unsigned RIB_DATA_W = 32;
    localparam int unsigned RIB_MASK_W = 4;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    // Round-robin pick between two requesters; last_grant breaks ties.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
        if (req0 && req1) begin
            return ~last_grant;
        end
        if (req1) begin
            return M_LSU;
        end
        return M_IFU;
    endfunction

endpackage

// File: rtl/rib_id_fifo.sv
// In-order FIFO of 1-bit master IDs: synchronous write, combinational read of the head entry.
module rib_id_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    // Pointers carry one extra wrap bit so their difference is the occupancy.
    localparam int unsigned PW = $clog2(DEPTH) + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == PW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    generate
        if (DEPTH == 1) begin : g_single
            // Single entry: the 1-bit pointers alone track occupancy.
            logic slot;

            always_ff @(posedge clk) begin
                if (do_push) begin
                    slot <= din;
                end
            end

            assign dout = slot;
        end else begin : g_multi
            localparam int unsigned AW = $clog2(DEPTH);

            logic mem [DEPTH];

            always_ff @(posedge clk) begin
                if (do_push) begin
                    mem[wr_ptr[AW-1:0]] <= din;
                end
            end

            assign dout = mem[rd_ptr[AW-1:0]];
        end
    endgenerate

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/rib_arb2to1.sv
// Two-master to one-slave RIB arbiter: round-robin request phase, in-order response routing via an ID FIFO.
module rib_arb2to1
    import rib_pkg::*;
#(
    parameter int unsigned OST_DEPTH = 2,
    parameter int unsigned ADDR_W    = RIB_ADDR_W,
    parameter int unsigned DATA_W    = RIB_DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,

    input  logic [ADDR_W-1:0]     i_m0_ribs_addr,
    input  logic                  i_m0_ribs_wrcs,
    input  logic [DATA_W/8-1:0]   i_m0_ribs_mask,
    input  logic [DATA_W-1:0]     i_m0_ribs_wdata,
    input  logic                  i_m0_ribs_req,
    output logic                  o_m0_ribs_gnt,
    output logic                  o_m0_ribs_rsp,
    input  logic                  i_m0_ribs_rdy,
    output logic [DATA_W-1:0]     o_m0_ribs_rdata,

    input  logic [ADDR_W-1:0]     i_m1_ribs_addr,
    input  logic                  i_m1_ribs_wrcs,
    input  logic [DATA_W/8-1:0]   i_m1_ribs_mask,
    input  logic [DATA_W-1:0]     i_m1_ribs_wdata,
    input  logic                  i_m1_ribs_req,
    output logic                  o_m1_ribs_gnt,
    output logic                  o_m1_ribs_rsp,
    input  logic                  i_m1_ribs_rdy,
    output logic [DATA_W-1:0]     o_m1_ribs_rdata,

    output logic [ADDR_W-1:0]     o_ribm_addr,
    output logic                  o_ribm_wrcs,
    output logic [DATA_W/8-1:0]   o_ribm_mask,
    output logic [DATA_W-1:0]     o_ribm_wdata,
    output logic                  o_ribm_req,
    input  logic                  i_ribm_gnt,
    input  logic                  i_ribm_rsp,
    output logic                  o_ribm_rdy,
    input  logic [DATA_W-1:0]     i_ribm_rdata,

    output logic                  o_err_unexp_rsp
);

    logic sel;
    logic last_grant;
    logic req_any;
    logic accept;
    logic pop;
    logic head;
    logic fifo_full;
    logic fifo_empty;
    logic err_q;

    assign req_any = i_m0_ribs_req | i_m1_ribs_req;
    assign sel     = rr_pick(i_m0_ribs_req, i_m1_ribs_req, last_grant);

    // Request path muxing; with no request active the m0 fields pass through.
    always_comb begin
        o_ribm_addr  = i_m0_ribs_addr;
        o_ribm_wrcs  = i_m0_ribs_wrcs;
        o_ribm_mask  = i_m0_ribs_mask;
        o_ribm_wdata = i_m0_ribs_wdata;
        if (sel == M_LSU) begin
            o_ribm_addr  = i_m1_ribs_addr;
            o_ribm_wrcs  = i_m1_ribs_wrcs;
            o_ribm_mask  = i_m1_ribs_mask;
            o_ribm_wdata = i_m1_ribs_wdata;
        end
    end

    // A full ID FIFO blocks new requests even when a pop lands in the same cycle.
    assign o_ribm_req    = i_rstn & req_any & ~fifo_full;
    assign accept        = o_ribm_req & i_ribm_gnt;
    assign o_m0_ribs_gnt = accept & (sel == M_IFU);
    assign o_m1_ribs_gnt = accept & (sel == M_LSU);

    assign o_m0_ribs_rsp = i_rstn & i_ribm_rsp & ~fifo_empty & (head == M_IFU);
    assign o_m1_ribs_rsp = i_rstn & i_ribm_rsp & ~fifo_empty & (head == M_LSU);
    assign o_ribm_rdy    = i_rstn & ~fifo_empty & ((head == M_LSU) ? i_m1_ribs_rdy : i_m0_ribs_rdy);
    assign pop           = i_ribm_rsp & o_ribm_rdy;

    assign o_m0_ribs_rdata = i_ribm_rdata;
    assign o_m1_ribs_rdata = i_ribm_rdata;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            last_grant <= M_LSU;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= sel;
            end
            if (i_ribm_rsp && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_err_unexp_rsp = err_q;

    rib_id_fifo #(
        .DEPTH (OST_DEPTH)
    ) u_id_fifo (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .push  (accept),
        .pop   (pop),
        .din   (sel),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    a_gnt_onehot: assert property (@(posedge i_clk) disable iff (!i_rstn)
        !(o_m0_ribs_gnt && o_m1_ribs_gnt));
    a_rsp_onehot: assert property (@(posedge i_clk) disable iff (!i_rstn)
        !(o_m0_ribs_rsp && o_m1_ribs_rsp));

endmodule

// File: tb/tb_rib_arb2to1.sv
// Scoreboard bench for rib_arb2to1: master BFMs, a 1-cycle slave model, and a response monitor.
module tb_rib_arb2to1;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rstn;
    logic [31:0] i_m0_ribs_addr, i_m1_ribs_addr;
    logic        i_m0_ribs_wrcs, i_m1_ribs_wrcs;
    logic [3:0]  i_m0_ribs_mask, i_m1_ribs_mask;
    logic [31:0] i_m0_ribs_wdata, i_m1_ribs_wdata;
    logic        i_m0_ribs_req, i_m1_ribs_req;
    logic        o_m0_ribs_gnt, o_m1_ribs_gnt;
    logic        o_m0_ribs_rsp, o_m1_ribs_rsp;
    logic        i_m0_ribs_rdy, i_m1_ribs_rdy;
    logic [31:0] o_m0_ribs_rdata, o_m1_ribs_rdata;
    logic [31:0] o_ribm_addr;
    logic        o_ribm_wrcs;
    logic [3:0]  o_ribm_mask;
    logic [31:0] o_ribm_wdata;
    logic        o_ribm_req;
    logic        i_ribm_gnt;
    logic        i_ribm_rsp;
    logic        o_ribm_rdy;
    logic [31:0] i_ribm_rdata;
    logic        o_err_unexp_rsp;

    txn_t        m0_q[$];
    txn_t        m1_q[$];
    exp_t        sb[$];
    logic [31:0] pend[$];
    exp_t        mon_e;

    logic        slv_hold  = 1'b0;
    logic        slv_force = 1'b0;
    logic        slv_acc;
    logic        slv_pop;
    logic [31:0] slv_acc_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rib_arb2to1 #(
        .OST_DEPTH (2),
        .ADDR_W    (32),
        .DATA_W    (32)
    ) dut (
        .i_clk           (clk),
        .i_rstn          (i_rstn),
        .i_m0_ribs_addr  (i_m0_ribs_addr),
        .i_m0_ribs_wrcs  (i_m0_ribs_wrcs),
        .i_m0_ribs_mask  (i_m0_ribs_mask),
        .i_m0_ribs_wdata (i_m0_ribs_wdata),
        .i_m0_ribs_req   (i_m0_ribs_req),
        .o_m0_ribs_gnt   (o_m0_ribs_gnt),
        .o_m0_ribs_rsp   (o_m0_ribs_rsp),
        .i_m0_ribs_rdy   (i_m0_ribs_rdy),
        .o_m0_ribs_rdata (o_m0_ribs_rdata),
        .i_m1_ribs_addr  (i_m1_ribs_addr),
        .i_m1_ribs_wrcs  (i_m1_ribs_wrcs),
        .i_m1_ribs_mask  (i_m1_ribs_mask),
        .i_m1_ribs_wdata (i_m1_ribs_wdata),
        .i_m1_ribs_req   (i_m1_ribs_req),
        .o_m1_ribs_gnt   (o_m1_ribs_gnt),
        .o_m1_ribs_rsp   (o_m1_ribs_rsp),
        .i_m1_ribs_rdy   (i_m1_ribs_rdy),
        .o_m1_ribs_rdata (o_m1_ribs_rdata),
        .o_ribm_addr     (o_ribm_addr),
        .o_ribm_wrcs     (o_ribm_wrcs),
        .o_ribm_mask     (o_ribm_mask),
        .o_ribm_wdata    (o_ribm_wdata),
        .o_ribm_req      (o_ribm_req),
        .i_ribm_gnt      (i_ribm_gnt),
        .i_ribm_rsp      (i_ribm_rsp),
        .o_ribm_rdy      (o_ribm_rdy),
        .i_ribm_rdata    (i_ribm_rdata),
        .o_err_unexp_rsp (o_err_unexp_rsp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | a);
    endfunction

    // Master BFMs: present queue head from just after the edge, retire it when granted.
    always @(posedge clk) begin
        #1;
        if (m0_q.size() > 0) begin
            i_m0_ribs_req   = 1'b1;
            i_m0_ribs_addr  = m0_q[0].addr;
            i_m0_ribs_wrcs  = m0_q[0].wr;
            i_m0_ribs_mask  = m0_q[0].mask;
            i_m0_ribs_wdata = m0_q[0].wdata;
        end else begin
            i_m0_ribs_req = 1'b0;
        end
        if (m1_q.size() > 0) begin
            i_m1_ribs_req   = 1'b1;
            i_m1_ribs_addr  = m1_q[0].addr;
            i_m1_ribs_wrcs  = m1_q[0].wr;
            i_m1_ribs_mask  = m1_q[0].mask;
            i_m1_ribs_wdata = m1_q[0].wdata;
        end else begin
            i_m1_ribs_req = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (o_m0_ribs_gnt && m0_q.size() > 0) m0_q.delete(0);
        if (o_m1_ribs_gnt && m1_q.size() > 0) m1_q.delete(0);
    end

    // Slave model: answers each accept in the following cycle unless held.
    always @(negedge clk) begin
        slv_acc      = o_ribm_req & i_ribm_gnt;
        slv_acc_addr = o_ribm_addr;
        slv_pop      = i_ribm_rsp & o_ribm_rdy;
    end

    always @(posedge clk) begin
        #2;
        if (!i_rstn) begin
            pend.delete();
        end else begin
            if (slv_pop && pend.size() > 0) pend.delete(0);
            if (slv_acc) pend.push_back(slv_data(slv_acc_addr));
        end
        i_ribm_rsp   = slv_force | (!slv_hold && pend.size() > 0);
        i_ribm_rdata = (pend.size() > 0) ? pend[0] : 32'h0;
    end

    // Response monitor
    always @(negedge clk) begin
        if (o_m0_ribs_rsp || o_m1_ribs_rsp) begin
            chk1("rsp_onehot", o_m0_ribs_rsp & o_m1_ribs_rsp, 1'b0);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp0=%b rsp1=%b expected no response", o_m0_ribs_rsp, o_m1_ribs_rsp);
            end else begin
                mon_e = sb.pop_front();
                chk1("rsp_id", o_m1_ribs_rsp, mon_e.id);
                chk("rsp_data", o_m1_ribs_rsp ? o_m1_ribs_rdata : o_m0_ribs_rdata, mon_e.data);
            end
        end
    end

    task automatic push_m0(input logic wr, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        txn_t t;
        t = '{wr: wr, addr: a, mask: m, wdata: d};
        m0_q.push_back(t);
    endtask

    task automatic push_m1(input logic wr, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        txn_t t;
        t = '{wr: wr, addr: a, mask: m, wdata: d};
        m1_q.push_back(t);
    endtask

    task automatic expect_rsp(input logic id, input logic [31:0] d);
        exp_t e;
        e = '{id: id, data: d};
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int unsigned k;
        k = 0;
        while ((m0_q.size() > 0 || m1_q.size() > 0 || sb.size() > 0 || pend.size() > 0) && k < 40) begin
            @(posedge clk);
            k++;
        end
        if (k >= 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got %0d pending responses expected 0", sb.size());
            m0_q.delete();
            m1_q.delete();
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1 i_rstn = 1'b0;
        m0_q.delete();
        m1_q.delete();
        @(negedge clk);
        @(negedge clk);
        #1 i_rstn = 1'b1;
    endtask

    logic [3:0] g0_pat;

    initial begin
        i_m0_ribs_addr = '0; i_m0_ribs_wrcs = 1'b0; i_m0_ribs_mask = '0; i_m0_ribs_wdata = '0;
        i_m1_ribs_addr = '0; i_m1_ribs_wrcs = 1'b0; i_m1_ribs_mask = '0; i_m1_ribs_wdata = '0;
        i_m0_ribs_req = 1'b0; i_m1_ribs_req = 1'b0;
        i_m0_ribs_rdy = 1'b1; i_m1_ribs_rdy = 1'b1;
        i_ribm_gnt = 1'b1; i_ribm_rsp = 1'b0; i_ribm_rdata = '0;
        i_rstn = 1'b1;
        #2 i_rstn = 1'b0;
        repeat (2) @(negedge clk);

        chk1("rst_ribm_req", o_ribm_req, 1'b0);
        chk1("rst_gnt0", o_m0_ribs_gnt, 1'b0);
        chk1("rst_gnt1", o_m1_ribs_gnt, 1'b0);
        chk1("rst_rdy", o_ribm_rdy, 1'b0);
        chk1("rst_err", o_err_unexp_rsp, 1'b0);
        #1 i_rstn = 1'b1;
        @(negedge clk);

        // Single master read
        #1 push_m0(1'b0, 32'h0000_0100, 4'hF, 32'h0);
        expect_rsp(1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk1("t1_gnt0", o_m0_ribs_gnt, 1'b1);
        chk1("t1_gnt1", o_m1_ribs_gnt, 1'b0);
        chk("t1_addr", o_ribm_addr, 32'h0000_0100);
        chk1("t1_wrcs", o_ribm_wrcs, 1'b0);
        @(negedge clk);
        chk1("t1_rsp0", o_m0_ribs_rsp, 1'b1);
        chk1("t1_rsp1", o_m1_ribs_rsp, 1'b0);
        chk("t1_rdata", o_m0_ribs_rdata, 32'hDEAD_BEEF);
        wait_idle();

        // Contention from reset: m0, m1, m0, m1
        do_reset();
        push_m0(1'b0, 32'h10, 4'hF, 32'h0);
        push_m0(1'b0, 32'h18, 4'hF, 32'h0);
        push_m1(1'b0, 32'h20, 4'hF, 32'h0);
        push_m1(1'b0, 32'h28, 4'hF, 32'h0);
        expect_rsp(1'b0, 32'hC0DE_0010);
        expect_rsp(1'b1, 32'hC0DE_0020);
        expect_rsp(1'b0, 32'hC0DE_0018);
        expect_rsp(1'b1, 32'hC0DE_0028);
        g0_pat = 4'b0101;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("t2_gnt0", o_m0_ribs_gnt, g0_pat[0]);
            chk1("t2_gnt1", o_m1_ribs_gnt, ~g0_pat[0]);
            g0_pat = g0_pat >> 1;
        end
        wait_idle();

        // Full backpressure with the slave holding its response
        #1 slv_hold = 1'b1;
        push_m1(1'b0, 32'h30, 4'hF, 32'h0);
        push_m1(1'b0, 32'h34, 4'hF, 32'h0);
        push_m1(1'b0, 32'h38, 4'hF, 32'h0);
        expect_rsp(1'b1, 32'hC0DE_0030);
        expect_rsp(1'b1, 32'hC0DE_0034);
        expect_rsp(1'b1, 32'hC0DE_0038);
        @(negedge clk);
        chk1("t3_c1_gnt1", o_m1_ribs_gnt, 1'b1);
        @(negedge clk);
        chk1("t3_c2_gnt1", o_m1_ribs_gnt, 1'b1);
        chk1("t3_c2_rsp1", o_m1_ribs_rsp, 1'b0);
        @(negedge clk);
        chk1("t3_c3_req", o_ribm_req, 1'b0);
        chk1("t3_c3_gnt1", o_m1_ribs_gnt, 1'b0);
        @(negedge clk);
        chk1("t3_c4_req", o_ribm_req, 1'b0);
        chk1("t3_c4_rsp1", o_m1_ribs_rsp, 1'b0);
        #1 slv_hold = 1'b0;
        @(negedge clk);
        chk1("t3_c5_rsp1", o_m1_ribs_rsp, 1'b1);
        chk1("t3_c5_req_nobypass", o_ribm_req, 1'b0);
        chk1("t3_c5_gnt1", o_m1_ribs_gnt, 1'b0);
        @(negedge clk);
        chk1("t3_c6_gnt1", o_m1_ribs_gnt, 1'b1);
        chk1("t3_c6_rsp1", o_m1_ribs_rsp, 1'b1);
        wait_idle();

        // Masked write from m1
        #1 push_m1(1'b1, 32'h0000_0204, 4'b0101, 32'h1122_3344);
        expect_rsp(1'b1, 32'hC0DE_0204);
        @(negedge clk);
        chk1("t4_gnt1", o_m1_ribs_gnt, 1'b1);
        chk1("t4_gnt0", o_m0_ribs_gnt, 1'b0);
        chk("t4_addr", o_ribm_addr, 32'h0000_0204);
        chk("t4_wdata", o_ribm_wdata, 32'h1122_3344);
        chk("t4_mask", {28'h0, o_ribm_mask}, 32'h5);
        chk1("t4_wrcs", o_ribm_wrcs, 1'b1);
        @(negedge clk);
        chk1("t4_rsp1", o_m1_ribs_rsp, 1'b1);
        @(negedge clk);
        chk1("t4_rsp1_once", o_m1_ribs_rsp, 1'b0);
        wait_idle();

        // Unexpected response with the FIFO empty
        chk1("t5_err_pre", o_err_unexp_rsp, 1'b0);
        #1 slv_force = 1'b1;
        @(negedge clk);
        chk1("t5_rsp0", o_m0_ribs_rsp, 1'b0);
        chk1("t5_rsp1", o_m1_ribs_rsp, 1'b0);
        chk1("t5_rdy", o_ribm_rdy, 1'b0);
        #1 slv_force = 1'b0;
        @(negedge clk);
        chk1("t5_err_set", o_err_unexp_rsp, 1'b1);
        repeat (3) @(negedge clk);
        chk1("t5_err_sticky", o_err_unexp_rsp, 1'b1);

        // Reset with two outstanding transactions
        #1 slv_hold = 1'b1;
        push_m1(1'b0, 32'h50, 4'hF, 32'h0);
        expect_rsp(1'b1, 32'hC0DE_0050);
        @(negedge clk);
        chk1("t6_gnt1", o_m1_ribs_gnt, 1'b1);
        #1 push_m0(1'b0, 32'h40, 4'hF, 32'h0);
        @(negedge clk);
        chk1("t6_gnt0", o_m0_ribs_gnt, 1'b1);
        #1 slv_hold = 1'b0;
        push_m0(1'b0, 32'h44, 4'hF, 32'h0);
        push_m1(1'b0, 32'h54, 4'hF, 32'h0);
        @(negedge clk);
        chk1("t6_rsp1_pre", o_m1_ribs_rsp, 1'b1);
        chk1("t6_req_full", o_ribm_req, 1'b0);
        #1 i_rstn = 1'b0;
        m0_q.delete();
        m1_q.delete();
        #1;
        chk1("t6_rst_rsp1", o_m1_ribs_rsp, 1'b0);
        chk1("t6_rst_rsp0", o_m0_ribs_rsp, 1'b0);
        chk1("t6_rst_rdy", o_ribm_rdy, 1'b0);
        chk1("t6_rst_req", o_ribm_req, 1'b0);
        chk1("t6_rst_gnt0", o_m0_ribs_gnt, 1'b0);
        chk1("t6_rst_gnt1", o_m1_ribs_gnt, 1'b0);
        chk1("t6_rst_err", o_err_unexp_rsp, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 push_m0(1'b0, 32'h60, 4'hF, 32'h0);
        push_m1(1'b0, 32'h70, 4'hF, 32'h0);
        expect_rsp(1'b0, 32'hC0DE_0060);
        expect_rsp(1'b1, 32'hC0DE_0070);
        i_rstn = 1'b1;
        @(negedge clk);
        chk1("t6_tie_gnt0", o_m0_ribs_gnt, 1'b1);
        chk1("t6_tie_gnt1", o_m1_ribs_gnt, 1'b0);
        @(negedge clk);
        chk1("t6_next_gnt1", o_m1_ribs_gnt, 1'b1);
        wait_idle();
        chk1("t6_err_clear", o_err_unexp_rsp, 1'b0);
        chk("sb_drained", sb.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
